// File: rtl/name_pattern_sequencer_pkg.sv
// Shared types and width helpers for the name-display pattern sequencer.
package name_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int len_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/name_pattern_sequencer_div_counter.sv
// Modulo-DIV prescaler: counts 0..DIV-1 while enabled, tc marks the last count.
module div_counter #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
   end

   assign tc = (r_cnt == LAST);

endmodule

// File: rtl/name_pattern_sequencer.sv
// Multi-channel column pattern player: each channel emits a square tone while its
// bit in the current column is set. Handshake: start (level) launches, stop aborts, done pulses.
module name_pattern_sequencer
   import name_pkg::*;
#(
   parameter int N_CH    = 8,
   parameter int DEPTH   = 16,
   parameter int HF_DIV  = 4,
   parameter int COL_DIV = 1000,
   localparam int AW     = addr_w(DEPTH),
   localparam int LW     = len_w(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [N_CH-1:0] wr_data,
   input  logic [LW-1:0]   len,
   input  logic            loop,
   input  logic            start,
   input  logic            stop,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   col_idx,
   output logic [N_CH-1:0] out,
   output state_t          dbg_state
);

   state_t          r_state, w_state_nxt;
   logic [N_CH-1:0] r_mem [DEPTH];
   logic [AW-1:0]   r_col, w_col_nxt;
   logic [N_CH-1:0] r_pat, w_pat_nxt;
   logic [N_CH-1:0] r_out, w_out_nxt;
   logic [LW-1:0]   r_len, w_len_nxt;
   logic            r_loop, w_loop_nxt;
   logic            r_done, w_done_nxt;

   logic            w_run;
   logic            w_tone_tc, w_col_tc;
   logic            w_tick, w_col_step;
   logic            w_last_col;
   logic [AW-1:0]   w_col_inc;

   assign w_run      = (r_state == RUN);
   assign w_tick     = w_run & w_tone_tc;
   assign w_col_step = w_run & w_col_tc;
   assign w_col_inc  = r_col + AW'(1);
   assign w_last_col = (LW'(r_col) + LW'(1)) >= r_len;

   // Prescalers are held at zero outside RUN so every playback starts in phase.
   div_counter #(.DIV(HF_DIV)) u_tone_div (
      .clk (clk),
      .rst (rst),
      .clr (!w_run),
      .en  (w_run),
      .tc  (w_tone_tc)
   );

   div_counter #(.DIV(COL_DIV)) u_col_div (
      .clk (clk),
      .rst (rst),
      .clr (!w_run),
      .en  (w_run),
      .tc  (w_col_tc)
   );

   // Pattern store: asynchronous read, so a load racing a write sees the old column.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_pat   <= '0;
         r_out   <= '0;
         r_len   <= '0;
         r_loop  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_col   <= w_col_nxt;
         r_pat   <= w_pat_nxt;
         r_out   <= w_out_nxt;
         r_len   <= w_len_nxt;
         r_loop  <= w_loop_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_col_nxt   = r_col;
      w_pat_nxt   = r_pat;
      w_len_nxt   = r_len;
      w_loop_nxt  = r_loop;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop && (len != '0)) begin
               w_state_nxt = RUN;
               w_len_nxt   = len;
               w_loop_nxt  = loop;
               w_col_nxt   = '0;
               w_pat_nxt   = r_mem[0];
            end
         end
         RUN: begin
            if (stop) begin
               w_state_nxt = IDLE;
            end else if (w_col_step) begin
               if (!w_last_col) begin
                  w_col_nxt = w_col_inc;
                  w_pat_nxt = r_mem[w_col_inc];
               end else if (r_loop) begin
                  w_col_nxt = '0;
                  w_pat_nxt = r_mem[0];
               end else begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Channels decide on next-cycle state/pattern so a bit that stays set keeps its phase.
   always_comb begin
      w_out_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
         if ((w_state_nxt == RUN) && w_pat_nxt[i]) begin
            w_out_nxt[i] = r_out[i] ^ w_tick;
         end
      end
   end

   always_comb begin
      busy      = w_run;
      done      = r_done;
      col_idx   = r_col;
      out       = r_out;
      dbg_state = r_state;
   end

endmodule

// File: tb/tb_name_pattern_sequencer.sv
// Scoreboarded bench: expected per-cycle words are queued at start of playback and popped as the DUT runs.
module tb_name_pattern_sequencer;
   import name_pkg::*;

   localparam int N_CH    = 8;
   localparam int DEPTH   = 16;
   localparam int HF_DIV  = 2;
   localparam int COL_DIV = 8;
   localparam int AW      = 4;
   localparam int LW      = 5;
   localparam int EW      = 3 + AW + N_CH;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            wr_en = 1'b0;
   logic [AW-1:0]   wr_addr = '0;
   logic [N_CH-1:0] wr_data = '0;
   logic [LW-1:0]   len = '0;
   logic            loop = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic            busy, done;
   logic [AW-1:0]   col_idx;
   logic [N_CH-1:0] out_s;
   state_t          dbg_state;

   logic [N_CH-1:0] bmem [DEPTH];
   logic [EW-1:0]   exp_q [$];
   int              n_checks = 0;
   int              n_fail = 0;

   name_pattern_sequencer #(
      .N_CH(N_CH), .DEPTH(DEPTH), .HF_DIV(HF_DIV), .COL_DIV(COL_DIV)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .len(len), .loop(loop), .start(start), .stop(stop),
      .busy(busy), .done(done), .col_idx(col_idx), .out(out_s), .dbg_state(dbg_state)
   );

   // Clock and reset
   always #5 clk = ~clk;

   // Driver tasks (all called right after a negedge)
   task automatic write_col(input int addr, input logic [N_CH-1:0] data);
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
      bmem[addr] = data;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Expected words derived from the channel rule: out[i] = bit ? prev[i]^tick(prev cycle) : 0
   task automatic push_expected(input int plen, input bit ploop, input int ncyc,
                                input int wr_cyc, input int wr_col, input logic [N_CH-1:0] wr_val);
      logic [N_CH-1:0] prev, cur, pat;
      bit              tick_prev, run_n, dn;
      int              k, col, c;
      prev = '0;
      tick_prev = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         k = (n - 1) / COL_DIV;
         run_n = ploop || (n <= plen * COL_DIV);
         col = ploop ? (k % plen) : k;
         cur = '0;
         if (run_n) begin
            c = k * COL_DIV + 1;
            pat = (wr_cyc != 0 && wr_col == col && (c - 1) > wr_cyc) ? wr_val : bmem[col];
            cur = pat & (prev ^ {N_CH{tick_prev}});
         end
         dn = !ploop && (n == plen * COL_DIV + 1);
         exp_q.push_back({run_n, run_n, dn, run_n ? AW'(col) : {AW{1'b0}}, cur});
         tick_prev = run_n && (((n - 1) % HF_DIV) == HF_DIV - 1);
         prev = cur;
      end
   endtask

   function automatic logic [EW-1:0] observe(input logic chk);
      return {chk, busy, done, chk ? col_idx : {AW{1'b0}}, out_s};
   endfunction

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({busy, done, col_idx, out_s} !== '0) begin
         n_fail++; $display("FAIL reset_initial got %h exp 0", {busy, done, col_idx, out_s});
      end
      rst = 1'b0;
      write_col(0, 8'hFF);
      write_col(1, 8'h3C);
      len = 2; loop = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idle_cycles(10);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, done, col_idx, out_s} !== '0) begin
            n_fail++; $display("FAIL reset_mid got %h exp 0", {busy, done, col_idx, out_s});
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || out_s !== '0) begin
            n_fail++; $display("FAIL reset_stays_idle busy %b out %h exp 0", busy, out_s);
         end
      end
   endtask

   task automatic test_basic();
      logic [EW-1:0] e;
      write_col(0, 8'hA5);
      write_col(1, 8'h0F);
      len = 2; loop = 1'b0; start = 1'b1;
      push_expected(2, 1'b0, 18, 0, 0, '0);
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (observe(e[EW-1]) !== e) begin
            n_fail++; $display("FAIL basic cyc %0d got %h exp %h", n, observe(e[EW-1]), e);
         end
      end
   endtask

   task automatic test_loop();
      logic [EW-1:0] e;
      write_col(2, 8'hC3);
      len = 3; loop = 1'b1; start = 1'b1;
      push_expected(3, 1'b1, 40, 0, 0, '0);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (observe(e[EW-1]) !== e) begin
            n_fail++; $display("FAIL loop cyc %0d got %h exp %h", n, observe(e[EW-1]), e);
         end
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || out_s !== '0 || done !== 1'b0) begin
         n_fail++; $display("FAIL loop_stop busy %b done %b out %h exp 0 0 00", busy, done, out_s);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL loop_stop_after busy %b done %b exp 0 0", busy, done);
         end
      end
   endtask

   task automatic test_start_corners();
      logic [EW-1:0] e;
      len = 0; loop = 1'b0; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL start_len0 busy %b done %b exp 0 0", busy, done);
         end
      end
      len = 2; stop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0) begin
            n_fail++; $display("FAIL start_and_stop busy %b exp 0", busy);
         end
      end
      stop = 1'b0;
      push_expected(2, 1'b0, 18, 0, 0, '0);
      for (int n = 1; n <= 18; n++) begin
         @(negedge clk);
         start = (n == 5 || n == 12);
         e = exp_q.pop_front();
         n_checks++;
         if (observe(e[EW-1]) !== e) begin
            n_fail++; $display("FAIL start_in_run cyc %0d got %h exp %h", n, observe(e[EW-1]), e);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_write_active();
      logic [EW-1:0] e;
      write_col(0, 8'h03);
      write_col(1, 8'h81);
      len = 2; loop = 1'b1; start = 1'b1;
      push_expected(2, 1'b1, 26, 4, 0, 8'h3C);
      for (int n = 1; n <= 26; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (observe(e[EW-1]) !== e) begin
            n_fail++; $display("FAIL write_active cyc %0d got %h exp %h", n, observe(e[EW-1]), e);
         end
         wr_en = (n == 4); wr_addr = '0; wr_data = 8'h3C;
      end
      wr_en = 1'b0;
      bmem[0] = 8'h3C;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic test_rst_run();
      logic [EW-1:0] e;
      len = 2; loop = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idle_cycles(10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({busy, done, col_idx, out_s} !== '0) begin
         n_fail++; $display("FAIL rst_run got %h exp 0", {busy, done, col_idx, out_s});
      end
      idle_cycles(2);
      start = 1'b1;
      push_expected(2, 1'b1, 12, 0, 0, '0);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (n == 1) start = 1'b0;
         e = exp_q.pop_front();
         n_checks++;
         if (observe(e[EW-1]) !== e) begin
            n_fail++; $display("FAIL rst_replay cyc %0d got %h exp %h", n, observe(e[EW-1]), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      idle_cycles(2);
      test_loop();
      test_start_corners();
      idle_cycles(2);
      test_write_active();
      test_rst_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
